// File: rtl/pc_pkg.sv
// Shared encodings for the 6502 program-counter unit: PC ops, vector selects,
// fetch-FSM states and default vector addresses.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_LOAD = 3'd2,
    PC_LDL  = 3'd3,
    PC_LDH  = 3'd4,
    PC_REL  = 3'd5
  } pc_op_e;

  typedef enum logic [1:0] {
    VSEL_RST = 2'd0,
    VSEL_NMI = 2'd1,
    VSEL_IRQ = 2'd2
  } vec_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEC_LO = 2'd1,
    ST_VEC_HI = 2'd2
  } vec_state_e;

  localparam logic [15:0] DEF_NMI_VEC = 16'hFFFA;
  localparam logic [15:0] DEF_RST_VEC = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VEC = 16'hFFFE;

endpackage

// File: rtl/pc_vec_fetch.sv
// Two-cycle vector fetch FSM: reads the low then high vector byte through the
// memory handshake and hands each byte to the PC register as a write strobe.
module pc_vec_fetch
  import pc_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter logic [15:0] NMI_VEC   = DEF_NMI_VEC,
  parameter logic [15:0] RST_VEC   = DEF_RST_VEC,
  parameter logic [15:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter bit          AUTO_BOOT = 1'b1
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              vec_req,
  input  logic [1:0]        vec_sel,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              busy,
  output logic              vec_done,
  output logic              wr_lo,
  output logic              wr_hi,
  output logic [7:0]        wr_data
);

  localparam logic [ADDR_W-1:0] NMI_A = NMI_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] RST_A = RST_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] IRQ_A = IRQ_VEC[ADDR_W-1:0];

  vec_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] vec_base_reg, vec_base_next;
  logic              vec_done_reg;

  always_comb begin
    state_next    = state_reg;
    vec_base_next = vec_base_reg;
    wr_lo         = 1'b0;
    wr_hi         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (vec_req) begin
          case (vec_sel)
            VSEL_RST: vec_base_next = RST_A;
            VSEL_NMI: vec_base_next = NMI_A;
            default:  vec_base_next = IRQ_A;  // IRQ and the spare code
          endcase
          state_next = ST_VEC_LO;
        end
      end
      ST_VEC_LO: begin
        if (mem_ack) begin
          wr_lo      = 1'b1;
          state_next = ST_VEC_HI;
        end
      end
      ST_VEC_HI: begin
        if (mem_ack) begin
          wr_hi      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_reg    <= AUTO_BOOT ? ST_VEC_LO : ST_IDLE;
      vec_base_reg <= RST_A;
      vec_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      vec_base_reg <= vec_base_next;
      vec_done_reg <= (state_reg == ST_VEC_HI) && mem_ack;
    end
  end

  always_comb begin
    case (state_reg)
      ST_VEC_LO: mem_addr = vec_base_reg;
      ST_VEC_HI: mem_addr = vec_base_reg + 1'b1;
      default:   mem_addr = '0;
    endcase
  end

  assign busy     = (state_reg != ST_IDLE);
  assign mem_rd   = busy;
  assign vec_done = vec_done_reg;
  assign wr_data  = mem_rdata;

endmodule

// File: rtl/pc_unit_v2.sv
// 6502 program counter with increment, absolute/byte-wise load, relative
// branch with page-cross flag, and an embedded vector fetch sequencer.
module pc_unit_v2
  import pc_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          OFFS_W    = 8,
  parameter logic [15:0] NMI_VEC   = DEF_NMI_VEC,
  parameter logic [15:0] RST_VEC   = DEF_RST_VEC,
  parameter logic [15:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter bit          AUTO_BOOT = 1'b1
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] din,
  input  logic [OFFS_W-1:0] offset,
  input  logic              vec_req,
  input  logic [1:0]        vec_sel,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              busy,
  output logic              vec_done,
  output logic              page_cross
);

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              page_cross_reg, page_cross_next;
  logic              wr_lo, wr_hi;
  logic [7:0]        wr_data;
  logic              fsm_busy;

  logic signed [OFFS_W-1:0] offset_s;
  logic [ADDR_W-1:0]        offset_ext;
  logic [ADDR_W-1:0]        rel_sum;

  pc_vec_fetch #(
    .ADDR_W    (ADDR_W),
    .NMI_VEC   (NMI_VEC),
    .RST_VEC   (RST_VEC),
    .IRQ_VEC   (IRQ_VEC),
    .AUTO_BOOT (AUTO_BOOT)
  ) u_vec_fetch (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .vec_req   (vec_req),
    .vec_sel   (vec_sel),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .busy      (fsm_busy),
    .vec_done  (vec_done),
    .wr_lo     (wr_lo),
    .wr_hi     (wr_hi),
    .wr_data   (wr_data)
  );

  assign offset_s   = offset;
  assign offset_ext = ADDR_W'(offset_s);
  assign rel_sum    = pc_reg + offset_ext;

  // Vector byte writes only happen while busy; ops only in IDLE without vec_req.
  always_comb begin
    pc_next         = pc_reg;
    page_cross_next = 1'b0;
    if (wr_lo) begin
      pc_next[7:0] = wr_data;
    end else if (wr_hi) begin
      pc_next[ADDR_W-1:8] = wr_data[ADDR_W-9:0];
    end else if (!fsm_busy && !vec_req) begin
      case (op)
        PC_INC:  pc_next = pc_reg + 1'b1;
        PC_LOAD: pc_next = din;
        PC_LDL:  pc_next[7:0] = din[7:0];
        PC_LDH:  pc_next[ADDR_W-1:8] = din[ADDR_W-9:0];
        PC_REL: begin
          pc_next         = rel_sum;
          page_cross_next = (rel_sum[ADDR_W-1:8] != pc_reg[ADDR_W-1:8]);
        end
        default: pc_next = pc_reg;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      pc_reg         <= '0;
      page_cross_reg <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      page_cross_reg <= page_cross_next;
    end
  end

  assign pc         = pc_reg;
  assign page_cross = page_cross_reg;
  assign busy       = fsm_busy;

endmodule
